// File: rtl/pixel_unpacker.sv
// Unpacks 24-bit RGB pixels from a 32-bit AXI-Stream video feed, tracks x/y/frame and flags
// tuser/tlast misalignment. Define PIXEL_UNPACKER_ERR_CNT_EN to add saturating error counters.
module pixel_unpacker #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof_err,
  output logic        eol_err,
  input  logic        err_clr,
  output logic [15:0] frame_cnt
`ifdef PIXEL_UNPACKER_ERR_CNT_EN
  ,
  output logic [15:0] sof_err_cnt,
  output logic [15:0] eol_err_cnt
`endif
);

  typedef enum logic [1:0] {Ph0, Ph1, Ph2, Ph3} phase_e;

  localparam logic [9:0] XLast = 10'(X_SIZE - 1);
  localparam logic [9:0] XPen  = 10'(X_SIZE - 2);
  localparam logic [8:0] YLast = 9'(Y_SIZE - 1);

  phase_e      phase_q, phase_d, ph_eff;
  logic        run_q;
  logic [23:0] res_q, res_d;
  logic [23:0] pix_d;
  logic [9:0]  nx_q, nx_d, ld_x;
  logic [8:0]  ny_q, ny_d, ld_y, ld_y_inc;
  logic        slot_free, in_fire, pix_fire, ph3_load, load;
  logic        line_done, early_eol, sof_ev, eol_ev;
  logic        unused_tkeep;

  assign unused_tkeep = ^in_stream_tkeep;

  // run_q keeps tready low until the first edge after reset release.
  assign slot_free        = !pix_valid || pix_ready;
  assign in_stream_tready = run_q && (phase_q != Ph3) && slot_free;
  assign in_fire          = in_stream_tvalid && in_stream_tready;
  assign pix_fire         = pix_valid && pix_ready;
  assign ph3_load         = run_q && (phase_q == Ph3) && slot_free;
  assign load             = in_fire || ph3_load;

  // A tuser word always restarts decoding as word0 at (0,0).
  assign ph_eff    = in_stream_tuser ? Ph0 : phase_q;
  assign ld_x      = (in_fire && in_stream_tuser) ? 10'd0 : nx_q;
  assign ld_y      = (in_fire && in_stream_tuser) ? 9'd0 : ny_q;
  assign ld_y_inc  = (ld_y == YLast) ? 9'd0 : ld_y + 9'd1;
  assign line_done = (ph_eff == Ph2) ? (ld_x == XPen) : (ld_x == XLast);
  assign early_eol = in_stream_tlast && !line_done;
  assign sof_ev    = in_fire && in_stream_tuser &&
                     ((phase_q != Ph0) || (nx_q != 10'd0) || (ny_q != 9'd0));
  assign eol_ev    = in_fire && (in_stream_tlast != line_done);

  always_comb begin
    phase_d = phase_q;
    res_d   = res_q;
    pix_d   = {pix_r, pix_g, pix_b};
    nx_d    = nx_q;
    ny_d    = ny_q;
    if (in_fire) begin
      case (ph_eff)
        Ph0: begin
          pix_d   = in_stream_tdata[23:0];
          res_d   = {16'd0, in_stream_tdata[31:24]};
          phase_d = Ph1;
        end
        Ph1: begin
          pix_d   = {in_stream_tdata[15:0], res_q[7:0]};
          res_d   = {8'd0, in_stream_tdata[31:16]};
          phase_d = Ph2;
        end
        Ph2: begin
          pix_d   = {in_stream_tdata[7:0], res_q[15:0]};
          res_d   = in_stream_tdata[31:8];
          phase_d = Ph3;
        end
        default: ;
      endcase
      // Early end of line drops any carried residue.
      if (early_eol) phase_d = Ph0;
    end else if (ph3_load) begin
      pix_d   = res_q;
      phase_d = Ph0;
    end
    if (load) begin
      if ((in_fire && early_eol) || (ld_x == XLast)) begin
        nx_d = 10'd0;
        ny_d = ld_y_inc;
      end else begin
        nx_d = ld_x + 10'd1;
        ny_d = ld_y;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      phase_q   <= Ph0;
      res_q     <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof_err   <= 1'b0;
      eol_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      run_q     <= 1'b1;
      phase_q   <= phase_d;
      res_q     <= res_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      pix_valid <= load || (pix_valid && !pix_ready);
      if (load) begin
        {pix_r, pix_g, pix_b} <= pix_d;
        pix_x                 <= ld_x;
        pix_y                 <= ld_y;
      end
      sof_err <= sof_ev || (sof_err && !err_clr);
      eol_err <= eol_ev || (eol_err && !err_clr);
      if (pix_fire && (pix_x == XLast) && (pix_y == YLast)) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef PIXEL_UNPACKER_ERR_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sof_err_cnt <= '0;
      eol_err_cnt <= '0;
    end else begin
      if (err_clr) sof_err_cnt <= {15'd0, sof_ev};
      else if (sof_ev && (sof_err_cnt != 16'hFFFF)) sof_err_cnt <= sof_err_cnt + 16'd1;
      if (err_clr) eol_err_cnt <= {15'd0, eol_ev};
      else if (eol_ev && (eol_err_cnt != 16'hFFFF)) eol_err_cnt <= eol_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: packs known pixels into words and scoreboards the output.
module tb_pixel_unpacker;
  localparam int unsigned XS = 640;
  localparam int unsigned YS = 12;  // short frames keep full-frame runs brief
  localparam int WPL = XS * 3 / 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] in_stream_tdata = '0;
  logic [3:0]  in_stream_tkeep = 4'hF;
  logic        in_stream_tuser = 1'b0;
  logic        in_stream_tlast = 1'b0;
  logic        in_stream_tvalid = 1'b0;
  logic        in_stream_tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        sof_err, eol_err;
  logic        err_clr = 1'b0;
  logic [15:0] frame_cnt;
`ifdef PIXEL_UNPACKER_ERR_CNT_EN
  logic [15:0] sof_err_cnt, eol_err_cnt;
`endif

  always #5 aclk = ~aclk;

  pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .in_stream_tdata  (in_stream_tdata),
    .in_stream_tkeep  (in_stream_tkeep),
    .in_stream_tuser  (in_stream_tuser),
    .in_stream_tlast  (in_stream_tlast),
    .in_stream_tvalid (in_stream_tvalid),
    .in_stream_tready (in_stream_tready),
    .pix_r            (pix_r),
    .pix_g            (pix_g),
    .pix_b            (pix_b),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .sof_err          (sof_err),
    .eol_err          (eol_err),
    .err_clr          (err_clr),
    .frame_cnt        (frame_cnt)
`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    ,
    .sof_err_cnt      (sof_err_cnt),
    .eol_err_cnt      (eol_err_cnt)
`endif
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          last_stall = 0;
  bit          bp_en = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pix_item(input logic [23:0] rgb, input int x, input int y);
    return {21'd0, rgb, 10'(x), 9'(y)};
  endfunction

  function automatic logic [23:0] pv(input int f, input int x, input int y);
    return {8'(y) ^ 8'(f * 16), 8'(x >> 2) ^ 8'(y * 3), 8'(x)};
  endfunction

  // Downstream ready: always 1, or a coin flip per cycle when backpressure is enabled.
  initial forever begin
    @(posedge aclk);
    #1;
    pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: every output handshake must match the head of the expected queue.
  initial begin : mon
    logic [63:0] e;
    forever begin
      @(negedge aclk);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check_val("pix_extra", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_val("pix", pix_item({pix_r, pix_g, pix_b}, int'(pix_x), int'(pix_y)), e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_word(input logic [31:0] d, input logic u, input logic l);
    int n;
    n = 0;
    in_stream_tdata  = d;
    in_stream_tuser  = u;
    in_stream_tlast  = l;
    in_stream_tvalid = 1'b1;
    @(negedge aclk);
    while (!in_stream_tready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    last_stall = n;
    if (!in_stream_tready) check_val("tready_timeout", 64'(n), 64'd0);
    @(posedge aclk);
    #1;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    in_stream_tlast  = 1'b0;
  endtask

  // early_w: word index carrying an early tlast (-1 normal tlast, -2 no tlast at all).
  // stop_w: stop after this word without tlast (-1 send the whole line).
  task automatic send_line(input int f, input int y, input bit sof, input int early_w,
                           input int stop_w);
    logic [23:0] p[4];
    logic [31:0] w[3];
    for (int g = 0; g < int'(XS) / 4; g++) begin
      for (int k = 0; k < 4; k++) p[k] = pv(f, 4 * g + k, y);
      w[0] = {p[1][7:0], p[0]};
      w[1] = {p[2][15:0], p[1][23:8]};
      w[2] = {p[3], p[2][23:16]};
      for (int j = 0; j < 3; j++) begin
        int wi;
        logic lst;
        wi  = 3 * g + j;
        lst = (early_w == -1) ? (wi == WPL - 1) : (wi == early_w);
        exp_q.push_back(pix_item(p[j], 4 * g + j, y));
        if (j == 2 && wi != early_w) exp_q.push_back(pix_item(p[3], 4 * g + 3, y));
        send_word(w[j], sof && (wi == 0), lst);
        if (wi == early_w || wi == stop_w) return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    check_val("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    #1;
    aresetn = 1'b0;
    exp_q.delete();
    in_stream_tvalid = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    // Reset values while aresetn is held low.
    #2;
    check_val("rst_tready", 64'(in_stream_tready), 64'd0);
    check_val("rst_valid", 64'(pix_valid), 64'd0);
    check_val("rst_rgb", 64'({pix_r, pix_g, pix_b}), 64'd0);
    check_val("rst_xy", 64'({pix_x, pix_y}), 64'd0);
    check_val("rst_flags", 64'({sof_err, eol_err}), 64'd0);
    check_val("rst_frame", 64'(frame_cnt), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("tready_before_edge", 64'(in_stream_tready), 64'd0);
    @(negedge aclk);
    check_val("tready_after_edge", 64'(in_stream_tready), 64'd1);
    @(posedge aclk);
    #1;

    // Aligned group; expected pixels follow the little-endian byte-stream packing.
    exp_q.push_back(pix_item(24'h332211, 0, 0));
    exp_q.push_back(pix_item(24'h554444, 1, 0));
    exp_q.push_back(pix_item(24'h666655, 2, 0));
    exp_q.push_back(pix_item(24'h998877, 3, 0));
    send_word(32'h44332211, 1'b1, 1'b0);
    check_val("w0_stall", 64'(last_stall), 64'd0);
    send_word(32'h66555544, 1'b0, 1'b0);
    check_val("w1_stall", 64'(last_stall), 64'd0);
    send_word(32'h99887766, 1'b0, 1'b0);
    check_val("w2_stall", 64'(last_stall), 64'd0);
    @(negedge aclk);
    check_val("ph3_tready", 64'(in_stream_tready), 64'd0);
    @(negedge aclk);
    check_val("ph0_tready", 64'(in_stream_tready), 64'd1);
    @(posedge aclk);
    #1;
    drain();
    check_val("aligned_flags", 64'({sof_err, eol_err}), 64'd0);

    // Full frame, then a second frame under random backpressure.
    apply_reset();
    for (int y = 0; y < int'(YS); y++) send_line(0, y, y == 0, -1, -1);
    drain();
    check_val("frame1_cnt", 64'(frame_cnt), 64'd1);
    check_val("frame1_flags", 64'({sof_err, eol_err}), 64'd0);
    bp_en = 1'b1;
    for (int y = 0; y < int'(YS); y++) send_line(1, y, y == 0, -1, -1);
    drain();
    bp_en = 1'b0;
    drain();
    check_val("frame2_cnt", 64'(frame_cnt), 64'd2);
    check_val("frame2_flags", 64'({sof_err, eol_err}), 64'd0);

    // Early tlast on word 100, then a mid-frame tuser at x=321, y=7.
    apply_reset();
    send_line(2, 0, 1'b1, 100, -1);
    drain();
    check_val("early_eol_err", 64'(eol_err), 64'd1);
    for (int y = 1; y < 7; y++) send_line(2, y, 1'b0, -1, -1);
    send_line(2, 7, 1'b0, -1, 240);
    exp_q.push_back(pix_item(24'hB2C3D4, 0, 0));
    send_word(32'hA1B2C3D4, 1'b1, 1'b0);
    drain();
    check_val("mid_sof_err", 64'(sof_err), 64'd1);
    check_val("mid_eol_keep", 64'(eol_err), 64'd1);
    check_val("mid_frame_cnt", 64'(frame_cnt), 64'd0);
`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    check_val("sof_cnt", 64'(sof_err_cnt), 64'd1);
    check_val("eol_cnt", 64'(eol_err_cnt), 64'd1);
`endif
    err_clr = 1'b1;
    @(posedge aclk);
    #1;
    err_clr = 1'b0;
    check_val("clr_flags", 64'({sof_err, eol_err}), 64'd0);
`ifdef PIXEL_UNPACKER_ERR_CNT_EN
    check_val("clr_cnts", 64'({sof_err_cnt, eol_err_cnt}), 64'd0);
`endif

    // Line-completing word without tlast: flag set, counting continues into the next line.
    apply_reset();
    send_line(3, 0, 1'b1, -2, -1);
    drain();
    check_val("missing_tlast_err", 64'(eol_err), 64'd1);
    send_line(3, 1, 1'b0, -1, -1);
    drain();
    check_val("missing_tlast_sof", 64'(sof_err), 64'd0);

    // Reset in PH2 with a pixel held: outputs drop without a clock edge.
    apply_reset();
    exp_q.push_back(pix_item(24'h332211, 0, 0));
    send_word(32'h44332211, 1'b0, 1'b0);
    exp_q.push_back(pix_item(24'h554444, 1, 0));
    send_word(32'h66555544, 1'b0, 1'b0);
    check_val("ph2_valid", 64'(pix_valid), 64'd1);
    #1;
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    check_val("async_valid", 64'(pix_valid), 64'd0);
    check_val("async_tready", 64'(in_stream_tready), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    exp_q.push_back(pix_item(24'h0B0C0D, 0, 0));
    send_word(32'h0A0B0C0D, 1'b0, 1'b0);
    drain();
    check_val("post_rst_flags", 64'({sof_err, eol_err}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
